// File: rtl/inport_in_buffer_pkg.sv
// Shared constants and helpers for the input-port flit buffer and its right-side interface.
// A stored flit word is laid out as {tail, head, data}.
package inport_in_buffer_pkg;

    localparam int default_flit_size = 1;
    localparam int default_phit_size = 16;

    typedef enum logic [1:0] {
        op_idle = 2'b00,
        op_pop  = 2'b01,
        op_push = 2'b10,
        op_both = 2'b11
    } fifo_op_e;

    function automatic int head_bit(input int flit_w);
        return flit_w;
    endfunction

    function automatic int tail_bit(input int flit_w);
        return flit_w + 1;
    endfunction

    // Index width for an array of depth entries; depth need not be a power of 2.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/inport_in_buffer_assembler.sv
// Collects phits into a flit and pulses push on the last phit; the last phit is
// not staged but fed straight into the flit word. flit_size=1 is a pass-through.
module inport_in_buffer_assembler
    import inport_in_buffer_pkg::*;
#(
    parameter int flit_size                   = default_flit_size,
    parameter int floorplusone_log2_flit_size = 1,
    parameter int phit_size                   = default_phit_size
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [phit_size-1:0]             in_phit,
    input  logic                             in_head,
    input  logic                             in_tail,
    input  logic                             accept,
    output logic [flit_size*phit_size+1:0]   flit_out,
    output logic                             push
);

    localparam int flit_w = flit_size * phit_size;
    localparam int pcw    = floorplusone_log2_flit_size;
    localparam logic [pcw-1:0] last_phit = pcw'(flit_size - 1);

    logic [pcw-1:0]    phit_cnt;
    logic              staged_head;
    logic              staged_tail;
    logic              is_first;
    logic [flit_w-1:0] flit_data;

    assign is_first = (phit_cnt == '0);
    assign push     = accept && (phit_cnt == last_phit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            phit_cnt    <= '0;
            staged_head <= 1'b0;
            staged_tail <= 1'b0;
        end else if (accept) begin
            phit_cnt <= (phit_cnt == last_phit) ? '0 : phit_cnt + pcw'(1);
            if (is_first) begin
                staged_head <= in_head;
                staged_tail <= in_tail;
            end
        end
    end

    if (flit_size > 1) begin : g_stage
        logic [(flit_size-1)*phit_size-1:0] staged;

        always_ff @(posedge clk) begin
            if (reset) begin
                staged <= '0;
            end else if (accept) begin
                for (int i = 0; i < flit_size - 1; i++) begin
                    if (phit_cnt == pcw'(i))
                        staged[i*phit_size +: phit_size] <= in_phit;
                end
            end
        end

        assign flit_data = {in_phit, staged};
    end else begin : g_pass
        assign flit_data = in_phit;
    end

    // Flags of a single-phit flit come from the phit itself, not the latch.
    always_comb begin
        flit_out                   = '0;
        flit_out[flit_w-1:0]       = flit_data;
        flit_out[head_bit(flit_w)] = is_first ? in_head : staged_head;
        flit_out[tail_bit(flit_w)] = is_first ? in_tail : staged_tail;
    end

endmodule

// File: rtl/inport_in_buffer.sv
// Input-port flit buffer: assembles phits into flits and keeps them in a circular
// FIFO, presenting the oldest flit first-word-fall-through and popping on want.
module inport_in_buffer
    import inport_in_buffer_pkg::*;
#(
    parameter int flit_size                      = default_flit_size,
    parameter int floorplusone_log2_flit_size    = 1,
    parameter int phit_size                      = default_phit_size,
    parameter int buffer_depth                   = 4,
    parameter int floorplusone_log2_buffer_depth = 3
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [phit_size-1:0]                      in_phit,
    input  logic                                      in_valid,
    input  logic                                      in_head,
    input  logic                                      in_tail,
    output logic                                      in_ready,
    input  logic                                      want,
    output logic [flit_size*phit_size-1:0]            indata,
    output logic                                      head,
    output logic                                      tail,
    output logic                                      empty,
    output logic [floorplusone_log2_buffer_depth-1:0] count
);

    localparam int flit_w = flit_size * phit_size;
    localparam int word_w = flit_w + 2;
    localparam int cw     = floorplusone_log2_buffer_depth;
    localparam int aw     = ptr_width(buffer_depth);
    localparam logic [aw-1:0] last_slot = aw'(buffer_depth - 1);

    logic [word_w-1:0] mem [buffer_depth];
    logic [aw-1:0]     rd_ptr;
    logic [aw-1:0]     wr_ptr;
    logic [cw-1:0]     count_q;
    logic [word_w-1:0] flit_word;
    logic [word_w-1:0] front;
    logic              full;
    logic              accept;
    logic              push;
    logic              pop;

    function automatic logic [aw-1:0] next_ptr(input logic [aw-1:0] p);
        return (p == last_slot) ? '0 : p + aw'(1);
    endfunction

    assign full     = (count_q == cw'(buffer_depth));
    assign empty    = (count_q == '0);
    assign in_ready = ~full;
    assign accept   = in_valid && in_ready;
    assign pop      = want && !empty;
    assign count    = count_q;

    inport_in_buffer_assembler #(
        .flit_size                   (flit_size),
        .floorplusone_log2_flit_size (floorplusone_log2_flit_size),
        .phit_size                   (phit_size)
    ) u_assembler (
        .clk      (clk),
        .reset    (reset),
        .in_phit  (in_phit),
        .in_head  (in_head),
        .in_tail  (in_tail),
        .accept   (accept),
        .flit_out (flit_word),
        .push     (push)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case (fifo_op_e'({push, pop}))
                op_push: count_q <= count_q + cw'(1);
                op_pop:  count_q <= count_q - cw'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; slots are only read while count
    // says they hold a written flit, and the outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= flit_word;
    end

    assign front  = mem[rd_ptr];
    assign indata = empty ? '0 : front[flit_w-1:0];
    assign head   = !empty && front[head_bit(flit_w)];
    assign tail   = !empty && front[tail_bit(flit_w)];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && full));
    a_count_in_range: assert property (@(posedge clk) disable iff (reset)
        count_q <= cw'(buffer_depth));
    a_no_wrap_from_full: assert property (@(posedge clk) disable iff (reset)
        full |=> (count_q != '0));
    a_no_wrap_from_empty: assert property (@(posedge clk) disable iff (reset)
        empty |=> !full);

endmodule

// File: tb/tb_inport_in_buffer.sv
// Directed bench: instance a (2-phit flits, depth 4) and instance b (1-phit flits, depth 3).
module tb_inport_in_buffer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] a_phit, b_phit;
    logic        a_valid, a_hd_in, a_tl_in, a_want, a_ready;
    logic        b_valid, b_hd_in, b_tl_in, b_want, b_ready;
    logic [31:0] a_data;
    logic [15:0] b_data;
    logic        a_head, a_tail, a_empty;
    logic        b_head, b_tail, b_empty;
    logic [2:0]  a_count;
    logic [1:0]  b_count;

    inport_in_buffer #(
        .flit_size(2), .floorplusone_log2_flit_size(2), .phit_size(16),
        .buffer_depth(4), .floorplusone_log2_buffer_depth(3)
    ) u_a (
        .clk(clk), .reset(reset), .in_phit(a_phit), .in_valid(a_valid),
        .in_head(a_hd_in), .in_tail(a_tl_in), .in_ready(a_ready), .want(a_want),
        .indata(a_data), .head(a_head), .tail(a_tail), .empty(a_empty), .count(a_count)
    );

    inport_in_buffer #(
        .flit_size(1), .floorplusone_log2_flit_size(1), .phit_size(16),
        .buffer_depth(3), .floorplusone_log2_buffer_depth(2)
    ) u_b (
        .clk(clk), .reset(reset), .in_phit(b_phit), .in_valid(b_valid),
        .in_head(b_hd_in), .in_tail(b_tl_in), .in_ready(b_ready), .want(b_want),
        .indata(b_data), .head(b_head), .tail(b_tail), .empty(b_empty), .count(b_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        valid;
        logic [15:0] phit;
        logic        hd;
        logic        tl;
        logic        want;
        logic        e_empty;
        logic [2:0]  e_count;
        logic        e_ready;
        logic [31:0] e_data;
        logic        e_head;
        logic        e_tail;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [15:0] p, input logic h, input logic t,
                                input logic w, input logic ee, input logic [2:0] ec, input logic er,
                                input logic [31:0] ed, input logic eh, input logic et);
        vec_t r;
        r.valid = v; r.phit = p; r.hd = h; r.tl = t; r.want = w;
        r.e_empty = ee; r.e_count = ec; r.e_ready = er; r.e_data = ed; r.e_head = eh; r.e_tail = et;
        return r;
    endfunction

    task automatic check_a(input string tag, input logic ee, input logic [2:0] ec, input logic er,
                           input logic [31:0] ed, input logic eh, input logic et);
        check({tag, "_empty"}, a_empty, ee);
        check({tag, "_count"}, a_count, ec);
        check({tag, "_ready"}, a_ready, er);
        check({tag, "_data"},  a_data,  ed);
        check({tag, "_head"},  a_head,  eh);
        check({tag, "_tail"},  a_tail,  et);
    endtask

    task automatic a_drive(input logic v, input logic [15:0] p, input logic h, input logic t, input logic w);
        a_valid = v; a_phit = p; a_hd_in = h; a_tl_in = t; a_want = w;
    endtask

    initial begin
        // vectors for instance a: assembly with a gap, fill to full, blocked link, drain
        vecs.push_back(mk(1, 16'hAAAA, 1, 0, 0,  1, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0,  1, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(1, 16'hBBBB, 0, 1, 0,  0, 1, 1, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 1, 1, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h1111, 0, 1, 0,  0, 1, 1, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h2222, 0, 0, 0,  0, 2, 1, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h3333, 0, 0, 0,  0, 2, 1, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h4444, 0, 0, 0,  0, 3, 1, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h5555, 1, 1, 0,  0, 3, 1, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h6666, 0, 0, 0,  0, 4, 0, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h7777, 0, 0, 0,  0, 4, 0, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h8888, 0, 0, 0,  0, 4, 0, 32'hBBBB_AAAA, 1, 0));
        vecs.push_back(mk(1, 16'h9999, 0, 0, 1,  0, 3, 1, 32'h2222_1111, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3, 1, 32'h2222_1111, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1,  0, 2, 1, 32'h4444_3333, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1,  0, 1, 1, 32'h6666_5555, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1,  1, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1,  1, 0, 1, 32'h0, 0, 0));

        reset = 1'b1;
        a_drive(0, 16'h0, 0, 0, 0);
        b_valid = 0; b_phit = '0; b_hd_in = 0; b_tl_in = 0; b_want = 0;
        tick();
        tick();

        // reset state and idle
        check_a("reset_a", 1, 0, 1, 32'h0, 0, 0);
        check("reset_b_empty", b_empty, 1);
        check("reset_b_ready", b_ready, 1);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_a("idle_a", 1, 0, 1, 32'h0, 0, 0);
            check("idle_b_count", b_count, 0);
            check("idle_b_data", b_data, 0);
        end

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            a_drive(vecs[i].valid, vecs[i].phit, vecs[i].hd, vecs[i].tl, vecs[i].want);
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_count, vecs[i].e_ready,
                    vecs[i].e_data, vecs[i].e_head, vecs[i].e_tail);
        end

        // steady stream with want=1: ten flits, pointers wrap, count never exceeds 1
        for (int k = 0; k < 10; k++) begin
            a_drive(1, 16'(16'hD000 + k), k == 0, k == 9, 1);
            tick();
            check_a($sformatf("stream%0d_p0", k), 1, 0, 1, 32'h0, 0, 0);
            a_drive(1, 16'(16'hE000 + k), k != 0, k != 9, 1);
            tick();
            check_a($sformatf("stream%0d_p1", k), 0, 1, 1,
                    {16'(16'hE000 + k), 16'(16'hD000 + k)}, k == 0, k == 9);
        end
        a_drive(0, 16'h0, 0, 0, 1);
        tick();
        check_a("stream_drained", 1, 0, 1, 32'h0, 0, 0);

        // reset mid-assembly with two flits stored; reset also overrides a push
        a_drive(1, 16'h0101, 1, 0, 0); tick();
        a_drive(1, 16'h0202, 0, 0, 0); tick();
        a_drive(1, 16'h0303, 0, 1, 0); tick();
        a_drive(1, 16'h0404, 0, 0, 0); tick();
        a_drive(1, 16'h0505, 0, 0, 0); tick();
        check("pre_reset_count", a_count, 2);
        a_drive(1, 16'h0606, 0, 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_drive(0, 16'h0, 0, 0, 0);
        check_a("mid_reset", 1, 0, 1, 32'h0, 0, 0);
        tick();
        check_a("post_reset_idle", 1, 0, 1, 32'h0, 0, 0);
        a_drive(1, 16'h1234, 1, 1, 0); tick();
        check_a("after_reset_p0", 1, 0, 1, 32'h0, 0, 0);
        a_drive(1, 16'h5678, 0, 0, 0); tick();
        check_a("after_reset_p1", 0, 1, 1, 32'h5678_1234, 1, 1);
        a_drive(0, 16'h0, 0, 0, 1); tick();
        check_a("after_reset_pop", 1, 0, 1, 32'h0, 0, 0);
        a_drive(0, 16'h0, 0, 0, 0);

        // depth 3: fill, drain, three rounds so pointers wrap at a non-power-of-2 depth
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                b_valid = 1; b_phit = 16'(16'hB000 + r*16 + i);
                b_hd_in = (i == 0); b_tl_in = (i == 2); b_want = 0;
                tick();
                check($sformatf("b_r%0d_fill%0d_count", r, i), b_count, i + 1);
                check($sformatf("b_r%0d_fill%0d_front", r, i), b_data, 16'(16'hB000 + r*16));
                check($sformatf("b_r%0d_fill%0d_head", r, i), b_head, 1);
            end
            b_valid = 0;
            check($sformatf("b_r%0d_full_ready", r), b_ready, 0);
            for (int i = 0; i < 3; i++) begin
                b_want = 1;
                tick();
                check($sformatf("b_r%0d_drain%0d_count", r, i), b_count, 2 - i);
                if (i < 2) begin
                    check($sformatf("b_r%0d_drain%0d_front", r, i), b_data, 16'(16'hB000 + r*16 + i + 1));
                    check($sformatf("b_r%0d_drain%0d_tail", r, i), b_tail, i == 1);
                end else begin
                    check($sformatf("b_r%0d_drain_empty", r), b_empty, 1);
                    check($sformatf("b_r%0d_drain_data", r), b_data, 0);
                end
            end
            b_want = 0;
        end

        // want while empty is ignored
        b_want = 1;
        tick();
        check("b_want_empty_count", b_count, 0);
        check("b_want_empty_ready", b_ready, 1);
        b_want = 0;

        // simultaneous push and pop keeps count
        b_valid = 1; b_phit = 16'hC001; b_hd_in = 1; b_tl_in = 0;
        tick();
        check("b_simul_pre_count", b_count, 1);
        b_phit = 16'hC002; b_hd_in = 0; b_tl_in = 1; b_want = 1;
        tick();
        check("b_simul_count", b_count, 1);
        check("b_simul_front", b_data, 16'hC002);
        check("b_simul_tail", b_tail, 1);
        b_valid = 0;
        tick();
        check("b_simul_drain_empty", b_empty, 1);
        b_want = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
